// File: rtl/pixel_stream_source_if.sv
// Solver read port and Avalon-ST pixel stream of pixel_stream_source.
// The master side is the pixel source; the slave side is memories plus sink.
interface pixel_stream_source_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
);
    logic [ID_W-1:0]   rd_solver_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              stream_ready;
    logic              stream_valid;
    logic [7:0]        stream_data;
    logic              stream_start;
    logic              stream_end;

    modport master (
        output rd_solver_id, rd_addr,
        output stream_valid, stream_data,
        output stream_start, stream_end,
        input  rd_data, stream_ready
    );

    modport slave (
        input  rd_solver_id, rd_addr,
        input  stream_valid, stream_data,
        input  stream_start, stream_end,
        output rd_data, stream_ready
    );
endinterface

// File: rtl/pixel_stream_source.sv
// Raster pixel iterator over interleaved solver memories with a
// credit-managed output FIFO feeding an Avalon-ST pixel stream.
module pixel_stream_source #(
    parameter int NUM_SOLVERS = 29,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int RD_LATENCY  = 2,
    parameter int DATA_W      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = 6,
    parameter int ADDR_W      = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       frame_done,
    output logic       busy,
    pixel_stream_source_if.master bus
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int PIX_W = $clog2(TOTAL);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    logic [RD_LATENCY-1:0] vld_q, sop_q, eop_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [9:0]            mem_q [FIFO_DEPTH];

    logic             start, issue, credit, last_pix;
    logic             wr, pop, eop_pop;
    logic [INF_W-1:0] inflight;
    logic [3:0]       d4;
    logic [7:0]       pix8;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = ISSUE;
            ISSUE:   if (issue && last_pix) state_d = DRAIN;
            DRAIN:   if (eop_pop) state_d = DONE;
            DONE:    state_d = en ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DONE is the frame-end cycle: pulse done and resample en
    always_comb begin
        start      = ((state_q == IDLE) || (state_q == DONE)) && en;
        issue      = (state_q == ISSUE) && credit;
        frame_done = (state_q == DONE);
        busy       = (state_q == ISSUE) || (state_q == DRAIN);
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + INF_W'(vld_q[i]);
    end

    assign credit   = (int'(inflight) + int'(cnt_q)) < FIFO_DEPTH;
    assign last_pix = (pix_q == PIX_W'(TOTAL - 1));

    // solver id wraps modulo NUM_SOLVERS; address steps once per wrap
    always_comb begin
        mode_d = mode_q;
        id_d   = id_q;
        addr_d = addr_q;
        pix_d  = pix_q;
        if (start) begin
            mode_d = mode;
            id_d   = '0;
            addr_d = '0;
            pix_d  = '0;
        end else if (issue) begin
            pix_d = pix_q + PIX_W'(1);
            if (id_q == ID_W'(NUM_SOLVERS - 1)) begin
                id_d   = '0;
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                id_d = id_q + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
            id_q   <= '0;
            addr_q <= '0;
            pix_q  <= '0;
            vld_q  <= '0;
            sop_q  <= '0;
            eop_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
            vld_q[0] <= issue;
            sop_q[0] <= issue && (pix_q == '0);
            eop_q[0] <= issue && last_pix;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                sop_q[i] <= sop_q[i-1];
                eop_q[i] <= eop_q[i-1];
            end
        end
    end

    if (DATA_W >= 4) begin : g_msb
        assign d4 = bus.rd_data[DATA_W-1 -: 4];
    end else begin : g_ext
        assign d4 = {{(4 - DATA_W){1'b0}}, bus.rd_data};
    end

    always_comb begin
        pix8 = {d4, d4};
        unique case (mode_q)
            2'd0: pix8 = {d4, d4};
            2'd1: pix8 = {d4, 4'h0};
            2'd2: pix8 = ~{d4, d4};
            2'd3: pix8 = (&bus.rd_data) ? 8'h00 : {d4, d4};
            default: pix8 = {d4, d4};
        endcase
    end

    assign wr      = vld_q[RD_LATENCY-1];
    assign pop     = (cnt_q != '0) && bus.stream_ready;
    assign eop_pop = pop && mem_q[rd_ptr_q][8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= {sop_q[RD_LATENCY-1], eop_q[RD_LATENCY-1], pix8};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({wr, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(wr && (cnt_q == CNT_W'(FIFO_DEPTH))));

    assign bus.rd_solver_id = id_q;
    assign bus.rd_addr      = addr_q;
    assign bus.stream_valid = (cnt_q != '0);
    assign bus.stream_data  = mem_q[rd_ptr_q][7:0];
    assign bus.stream_start = mem_q[rd_ptr_q][9];
    assign bus.stream_end   = mem_q[rd_ptr_q][8];
endmodule
